// File: rtl/firc_pkg.sv
// Shared constants for the FIR sample path.
// Also holds the range helper used by the FIFO's parameter checks.
package firc_pkg;

  localparam int unsigned SAMP_W      = 24;
  localparam int unsigned COEF_W      = 27;
  localparam int unsigned NTAPS       = 29;
  localparam int unsigned FIFO_AWIDTH = 3;

  // True when lo <= v <= hi; evaluated at elaboration for parameter checks.
  function automatic bit lvl_in_range(input int unsigned v,
                                      input int unsigned lo,
                                      input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/cplx_fifo_ram.sv
// Single-write, single-read storage for the I/Q FIFO.
// Reads are combinational (asynchronous). The storage array is not reset.
module cplx_fifo_ram #(
  parameter int unsigned WIDTH  = 48,
  parameter int unsigned AWIDTH = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cplx_fifo.sv
// Parametrised first-word-fall-through I/Q sample FIFO.
// It provides an occupancy count, programmable almost-full/almost-empty thresholds, and sticky error flags.
module cplx_fifo
  import firc_pkg::*;
#(
  parameter int unsigned DWIDTH     = SAMP_W,
  parameter int unsigned AWIDTH     = FIFO_AWIDTH,
  parameter int unsigned AFULL_LVL  = 6,
  parameter int unsigned AEMPTY_LVL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DWIDTH-1:0] write_data1,
  input  logic [DWIDTH-1:0] write_data2,
  input  logic              rd,
  output logic [DWIDTH-1:0] read_data1,
  output logic [DWIDTH-1:0] read_data2,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam int unsigned CW    = AWIDTH + 1;

  if (AWIDTH < 1) begin : g_bad_awidth
    $error("cplx_fifo: AWIDTH must be at least 1");
  end
  if (!lvl_in_range(AFULL_LVL, 1, DEPTH)) begin : g_bad_afull
    $error("cplx_fifo: AFULL_LVL must lie in 1..DEPTH");
  end
  if (!lvl_in_range(AEMPTY_LVL, 0, DEPTH - 1)) begin : g_bad_aempty
    $error("cplx_fifo: AEMPTY_LVL must lie in 0..DEPTH-1");
  end

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic              pop_ok;
  logic              push_ok;
  logic              ovf_set;
  logic              udf_set;
  logic [CW-1:0]     count_next;
  logic [2*DWIDTH-1:0] ram_rdata;

  // Accept decode: a pop frees a slot, so a full FIFO can take a push alongside it.
  always_comb begin
    pop_ok     = rd & ~empty;
    push_ok    = wr & (~full | pop_ok);
    ovf_set    = wr & full & ~pop_ok;
    udf_set    = rd & empty;
    count_next = count + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointers advance only on accepted operations and wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AWIDTH'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AWIDTH'(1);
      end
    end
  end

  // Status flags are decoded from the next count, so they are registered together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == CW'(DEPTH));
      almost_full  <= (count_next >= CW'(AFULL_LVL));
      almost_empty <= (count_next <= CW'(AEMPTY_LVL));
    end
  end

  // Sticky error flags; a new event wins over clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= udf_set | (underflow & ~clr_err);
    end
  end

  cplx_fifo_ram #(
    .WIDTH  (2 * DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata ({write_data2, write_data1}),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign read_data1 = ram_rdata[DWIDTH-1:0];
  assign read_data2 = ram_rdata[2*DWIDTH-1:DWIDTH];

endmodule

// File: tb/tb_cplx_fifo.sv
// Directed and random bench for cplx_fifo with DWIDTH=24, AWIDTH=3, AFULL_LVL=6 and AEMPTY_LVL=1.
// The random phase checks the FIFO against a reference queue.
module tb_cplx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [23:0] write_data1;
  logic [23:0] write_data2;
  logic        rd;
  logic [23:0] read_data1;
  logic [23:0] read_data2;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
  logic        clr_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cplx_fifo #(
    .DWIDTH     (24),
    .AWIDTH     (3),
    .AFULL_LVL  (6),
    .AEMPTY_LVL (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .write_data1  (write_data1),
    .write_data2  (write_data2),
    .rd           (rd),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, sample 1ns later, then return inputs to idle.
  task automatic cyc(input logic w, input logic r, input logic [23:0] d, input logic c);
    wr = w; rd = r; write_data1 = d; write_data2 = ~d; clr_err = c;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] c, input logic e, input logic f,
                           input logic af, input logic ae, input logic ov, input logic uf);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".afull"}, 32'(almost_full), 32'(af));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(ae));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
    chk({tag, ".udf"}, 32'(underflow), 32'(uf));
  endtask

  task automatic chk_head(input string tag, input logic [23:0] d);
    logic [23:0] q;
    q = ~d;
    chk({tag, ".i"}, 32'(read_data1), 32'(d));
    chk({tag, ".q"}, 32'(read_data2), 32'(q));
  endtask

  initial begin
    logic [23:0] model [$];
    logic [23:0] exp_drain [9];
    logic        m_ovf;
    logic        m_udf;
    logic        w, r, c, pop_ok, push_ok;
    logic [23:0] d;
    int          sz;

    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    write_data1 = '0; write_data2 = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Reset followed by an idle cycle.
    cyc(1'b0, 1'b0, 24'h0, 1'b0);
    chk_flags("reset", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill with 1..8: almost_full is set from a count of 6, and full is set at 8.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 24'(i), 1'b0);
      chk_flags($sformatf("fill%0d", i), 4'(i), 1'b0, (i == 8), (i >= 6), (i <= 1), 1'b0, 1'b0);
      chk_head($sformatf("fill%0d.head", i), 24'h000001);
    end
    cyc(1'b1, 1'b0, 24'h000009, 1'b0);
    chk_flags("push_full", 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_head("push_full.head", 24'h000001);

    // Push and pop on the same cycle while full; count stays at 8.
    cyc(1'b1, 1'b1, 24'h0000AA, 1'b0);
    chk_flags("wrrd_full", 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_drain = '{24'h2, 24'h3, 24'h4, 24'h5, 24'h6, 24'h7, 24'h8, 24'hAA, 24'h0};
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("drain%0d", i), exp_drain[i]);
      cyc(1'b0, 1'b1, 24'h0, 1'b0);
      chk($sformatf("drain%0d.count", i), 32'(count), 32'(7 - i));
    end
    chk_flags("drained", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Pop on empty, first without a push and then with one.
    cyc(1'b0, 1'b1, 24'h0, 1'b0);
    chk_flags("udf_nowr", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 24'h0, 1'b1);
    chk_flags("clr1", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 24'h123456, 1'b0);
    chk_flags("udf_wr", 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_head("udf_wr.head", 24'h123456);

    // clr_err on its own, then clr_err on the same cycle as a new overflow.
    cyc(1'b0, 1'b0, 24'h0, 1'b1);
    chk_flags("clr2", 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 24'(24'h100 + i), 1'b0);
    chk_flags("refill", 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 24'hDEAD00, 1'b1);
    chk_flags("ovf_vs_clr", 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_head("ovf_vs_clr.head", 24'h123456);

    // Reset mid-stream at a count of 5, with wr held high.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 24'h0, 1'b0);
    chk("pre_rst.count", 32'(count), 32'd5);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 24'h777777, 1'b0);
    rst = 1'b0;
    chk_flags("mid_rst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic compared against a reference queue.
    m_ovf = 1'b0; m_udf = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 15) == 0);
      d = 24'($urandom);
      sz = model.size();
      pop_ok  = r && (sz > 0);
      push_ok = w && ((sz < 8) || pop_ok);
      m_ovf = (w && (sz == 8) && !pop_ok) || (m_ovf && !c);
      m_udf = (r && (sz == 0)) || (m_udf && !c);
      cyc(w, r, d, c);
      if (pop_ok) void'(model.pop_front());
      if (push_ok) model.push_back(d);
      sz = model.size();
      chk_flags("rnd", 4'(sz), (sz == 0), (sz == 8), (sz >= 6), (sz <= 1), m_ovf, m_udf);
      if (sz > 0) chk_head("rnd.head", model[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
